zle_dec: RTL and testbench

- Zero run-length decoder, the inverse of the ZLE encoder datapath.
- Consumes a token stream (literal symbols and zero-run tokens) and re-expands it into the original SYM_W-bit symbol stream, one symbol per cycle.
- Sits at the receive end of the ZLE link, directly after the token channel.
- Valid/ready streams on both sides. Output is registered. No EOS handling.

---
 rtl/zle_pkg.sv | 26 ++
 rtl/zle_dec.sv | 96 +++++++++
 tb/tb_zle_dec.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/zle_pkg.sv
// Shared definitions for the ZLE encoder/decoder pair: token layout,
// token field helpers and the decoder state encoding.
package zle_pkg;

    // Symbol width; a token carries one extra flag bit on top.
    localparam int SYM_W    = 3;
    localparam int TOK_W    = SYM_W + 1;
    localparam int FLAG_BIT = SYM_W;

    // Decoder states: pass tokens through, or expand a pending zero run.
    typedef enum logic {
        S_PASS = 1'b0,
        S_RUN  = 1'b1
    } dec_state_t;

    // A token with the flag bit set describes a zero run.
    function automatic logic is_run(input logic [TOK_W-1:0] tok);
        return tok[FLAG_BIT];
    endfunction

    // Run field: the run length minus one.
    function automatic logic [SYM_W-1:0] run_field(input logic [TOK_W-1:0] tok);
        return tok[SYM_W-1:0];
    endfunction

endpackage : zle_pkg

// File: rtl/zle_dec.sv
// Zero run-length decoder. Re-expands literal and zero-run tokens into
// a symbol stream, one symbol per cycle, behind a registered output stage.
module zle_dec #(
    parameter int SYM_W = zle_pkg::SYM_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SYM_W:0]   i_d,
    input  logic             i_v,
    output logic             i_r,
    output logic [SYM_W-1:0] o_d,
    output logic             o_v,
    input  logic             o_r,
    output logic             busy
);
    import zle_pkg::*;

    dec_state_t       state_q, state_d;
    logic [SYM_W-1:0] rem_q;
    logic [SYM_W-1:0] o_d_q;
    logic             o_v_q;

    logic             free;
    logic             accept;
    logic             tok_run;
    logic [SYM_W-1:0] tok_val;

    // Output stage can take a new symbol when empty or being drained now.
    assign free    = !o_v_q || o_r;
    // Input is only accepted outside a run and outside reset, so a token
    // presented while i_r is low never influences any state.
    assign i_r     = reset && (state_q == S_PASS) && free;
    assign accept  = i_v && i_r;
    assign tok_run = i_d[SYM_W];
    assign tok_val = i_d[SYM_W-1:0];

    assign o_d  = o_d_q;
    assign o_v  = o_v_q;
    assign busy = (state_q == S_RUN);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a run longer than one enters S_RUN; the last zero returns.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_PASS: begin
                if (accept && tok_run && (tok_val != '0)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (free && (rem_q == SYM_W'(1))) begin
                    state_d = S_PASS;
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    // Remaining-count and output register; everything freezes while the
    // downstream stalls so no symbol is lost or duplicated.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            o_d_q <= '0;
            o_v_q <= 1'b0;
        end else if (free) begin
            if (state_q == S_RUN) begin
                o_d_q <= '0;
                o_v_q <= 1'b1;
                rem_q <= rem_q - SYM_W'(1);
            end else if (accept) begin
                o_v_q <= 1'b1;
                if (tok_run) begin
                    // First zero of the run goes out immediately; rem counts
                    // the zeros still owed after this one.
                    o_d_q <= '0;
                    rem_q <= tok_val;
                end else begin
                    o_d_q <= tok_val;
                end
            end else begin
                o_v_q <= 1'b0;
            end
        end
    end

endmodule : zle_dec

// File: tb/tb_zle_dec.sv
// Directed bench for zle_dec with a symbol scoreboard: expected symbols are
// queued when a token is accepted and checked as the DUT emits them.
module tb_zle_dec;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] i_d   = 4'd0;
    logic       i_v   = 1'b0;
    logic       i_r;
    logic [2:0] o_d;
    logic       o_v;
    logic       o_r   = 1'b1;
    logic       busy;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [2:0] exp_q[$];
    int cyc        = 0;
    int tx_cnt     = 0;
    int seg_first  = -1;
    int tx_last    = -1;
    int acc_cyc    = 0;

    zle_dec #(.SYM_W(3)) dut (
        .clock(clock),
        .reset(reset),
        .i_d  (i_d),
        .i_v  (i_v),
        .i_r  (i_r),
        .o_d  (o_d),
        .o_v  (o_v),
        .o_r  (o_r),
        .busy (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: a symbol is transferred at the next rising edge.
    always @(negedge clock) begin
        if (reset && o_v && o_r) begin
            if (exp_q.size() == 0) begin
                n_asserts++;
                n_fails++;
                $error("FAIL unexpected_out: observed %0h expected none", o_d);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("sym", {29'd0, o_d}, {29'd0, e});
            end
            $display("out cyc=%0d o_d=%0d", cyc, o_d);
            tx_cnt++;
            if (seg_first < 0) seg_first = cyc;
            tx_last = cyc;
        end
    end

    // Present a token, wait (bounded) for acceptance, queue its symbols.
    task automatic send(input logic [3:0] tok, input bit first,
                        output int waits, output int busys);
        bit ok;
        ok = 0; waits = 0; busys = 0;
        i_d = tok; i_v = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (busy) busys++;
            if (i_r) begin ok = 1; break; end
            waits++;
        end
        chk("accept", {31'd0, ok}, 32'd1);
        if (tok[3]) begin
            for (int z = 0; z <= int'(tok[2:0]); z++) exp_q.push_back(3'd0);
        end else begin
            exp_q.push_back(tok[2:0]);
        end
        $display("in  tok=%b waits=%0d busy_cycles=%0d", tok, waits, busys);
        @(posedge clock); #1;
        if (first) acc_cyc = cyc;
        i_v = 1'b0;
        i_d = 4'($urandom);
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !o_v) begin ok = 1; break; end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic seg_start();
        @(posedge clock); #1;
        seg_first = -1;
    endtask

    initial begin
        int w, b, w2, b2, base;
        logic [2:0] hold_d;
        logic       hold_v;

        // Reset held: outputs idle, input not ready.
        #12;
        chk("rst_ir", {31'd0, i_r}, 32'd0);
        chk("rst_ov", {31'd0, o_v}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("idle_ov",   {31'd0, o_v},  32'd0);
        chk("idle_od",   {29'd0, o_d},  32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ir",   {31'd0, i_r},  32'd1);

        // Back-to-back literals: 5, 3, 7 on consecutive cycles.
        seg_start();
        send(4'b0101, 1, w, b);  chk("lit_wait0", w, 0);
        send(4'b0011, 0, w, b);  chk("lit_wait1", w, 0);
        send(4'b0111, 0, w, b);  chk("lit_wait2", w, 0);
        drain("lit_drain");
        chk("lit_latency", seg_first, acc_cyc);
        chk("lit_contig",  tx_last - seg_first, 2);
        chk("lit_ov_fall", {31'd0, o_v}, 32'd0);

        // Run L=3 then literal 1: 0,0,0,1; input stalled 2 cycles.
        seg_start();
        send(4'b1010, 1, w, b);
        chk("run3_busy_at_acc", b, 0);
        send(4'b0001, 0, w2, b2);
        chk("run3_ir_low", w2, 2);
        chk("run3_busy",   b2, 2);
        drain("run3_drain");
        chk("run3_contig", tx_last - seg_first, 3);

        // Run L=8 with a 2-cycle downstream stall in the middle.
        seg_start();
        base = tx_cnt;
        send(4'b1111, 1, w, b);
        @(posedge clock); #1;
        @(posedge clock); #1;
        o_r = 1'b0;
        hold_d = o_d; hold_v = o_v;
        chk("run8_mid_busy", {31'd0, busy}, 32'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("run8_hold_ov", {31'd0, o_v}, {31'd0, hold_v});
        chk("run8_hold_od", {29'd0, o_d}, {29'd0, hold_d});
        chk("run8_hold_ir", {31'd0, i_r}, 32'd0);
        o_r = 1'b1;
        drain("run8_drain");
        chk("run8_count", tx_cnt - base, 8);
        chk("run8_span",  tx_last - seg_first, 9);

        // Run L=1 then literal 6: no stall, busy never seen.
        seg_start();
        send(4'b1000, 1, w, b);
        send(4'b0110, 0, w2, b2);
        chk("run1_wait", w2, 0);
        chk("run1_busy", b + b2, 0);
        drain("run1_drain");
        chk("run1_contig", tx_last - seg_first, 1);

        // Run L=7 cut short by reset after 3 zeros.
        seg_start();
        base = tx_cnt;
        send(4'b1110, 1, w, b);
        begin
            bit ok;
            ok = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clock);
                if (tx_cnt >= base + 3) begin ok = 1; break; end
            end
            chk("rstmid_reach3", {31'd0, ok}, 32'd1);
        end
        #1;
        chk("rstmid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("rstmid_ov",   {31'd0, o_v},  32'd0);
        chk("rstmid_od",   {29'd0, o_d},  32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_ir",   {31'd0, i_r},  32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        base = tx_cnt;
        send(4'b0010, 0, w, b);
        chk("postrst_wait", w, 0);
        drain("postrst_drain");
        repeat (4) @(posedge clock);
        #1;
        chk("postrst_count", tx_cnt - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule : tb_zle_dec
